// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: maps MIDI note-on/off events onto VOICES note slots,
// reusing a matching voice, then a free voice, then stealing the least-recently-allocated one.
module voice_alloc #(
  parameter int VOICES = 4,
  parameter int RANK_W = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CE,
  input  logic                  EV_VALID,
  input  logic                  EV_ON,
  input  logic [6:0]            EV_NOTE,
  input  logic [6:0]            EV_VEL,
  input  logic                  ALL_OFF,
  output logic [VOICES*7-1:0]   VOICE_NOTE,
  output logic [VOICES*7-1:0]   VOICE_VEL,
  output logic [VOICES-1:0]     VOICE_GATE,
  output logic [VOICES-1:0]     VOICE_TRIG,
  output logic                  STEAL
);

  localparam logic [RANK_W-1:0] OLDEST = RANK_W'(VOICES - 1);

  logic [6:0]        note_q [VOICES];
  logic [6:0]        vel_q  [VOICES];
  logic [RANK_W-1:0] rank_q [VOICES];
  logic [VOICES-1:0] gate_q;
  logic [VOICES-1:0] trig_q;
  logic              steal_q;

  logic [6:0]        note_d [VOICES];
  logic [6:0]        vel_d  [VOICES];
  logic [RANK_W-1:0] rank_d [VOICES];
  logic [VOICES-1:0] gate_d;
  logic [VOICES-1:0] trig_d;
  logic              steal_d;

  logic              is_on;
  logic              match_hit;
  logic              free_hit;
  logic [RANK_W-1:0] match_idx;
  logic [RANK_W-1:0] free_idx;
  logic [RANK_W-1:0] oldest_idx;
  logic [RANK_W-1:0] target;
  logic              do_steal;
  logic [VOICES-1:0] off_mask;

  // Velocity 0 on a note-on is a note-off (running-status convention).
  assign is_on = EV_ON && (EV_VEL != 7'd0);

  // Scan downward so the lowest index wins each priority class.
  always_comb begin
    match_hit  = 1'b0;
    free_hit   = 1'b0;
    match_idx  = '0;
    free_idx   = '0;
    oldest_idx = '0;
    off_mask   = '0;
    for (int i = VOICES - 1; i >= 0; i--) begin
      if (gate_q[i] && (note_q[i] == EV_NOTE)) begin
        match_hit   = 1'b1;
        match_idx   = RANK_W'(i);
        off_mask[i] = 1'b1;
      end
      if (!gate_q[i]) begin
        free_hit = 1'b1;
        free_idx = RANK_W'(i);
      end
      if (rank_q[i] == OLDEST) begin
        oldest_idx = RANK_W'(i);
      end
    end
    do_steal = !match_hit && !free_hit;
    if (match_hit) begin
      target = match_idx;
    end else if (free_hit) begin
      target = free_idx;
    end else begin
      target = oldest_idx;
    end
  end

  always_comb begin
    note_d  = note_q;
    vel_d   = vel_q;
    rank_d  = rank_q;
    gate_d  = gate_q;
    trig_d  = '0;
    steal_d = 1'b0;
    if (ALL_OFF) begin
      gate_d = '0;
    end else if (EV_VALID) begin
      if (is_on) begin
        note_d[target] = EV_NOTE;
        vel_d[target]  = EV_VEL;
        gate_d[target] = 1'b1;
        trig_d[target] = 1'b1;
        steal_d        = do_steal;
        // Age everything newer than the target, then make the target newest.
        for (int j = 0; j < VOICES; j++) begin
          if (rank_q[j] < rank_q[target]) begin
            rank_d[j] = rank_q[j] + RANK_W'(1);
          end
        end
        rank_d[target] = '0;
      end else begin
        gate_d = gate_q & ~off_mask;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < VOICES; i++) begin
        note_q[i] <= '0;
        vel_q[i]  <= '0;
        rank_q[i] <= RANK_W'(i);
      end
      gate_q  <= '0;
      trig_q  <= '0;
      steal_q <= 1'b0;
    end else if (CE) begin
      note_q  <= note_d;
      vel_q   <= vel_d;
      rank_q  <= rank_d;
      gate_q  <= gate_d;
      trig_q  <= trig_d;
      steal_q <= steal_d;
    end else begin
      trig_q  <= '0;
      steal_q <= 1'b0;
    end
  end

  for (genvar g = 0; g < VOICES; g++) begin : g_pack
    assign VOICE_NOTE[7*g +: 7] = note_q[g];
    assign VOICE_VEL[7*g +: 7]  = vel_q[g];
  end

  assign VOICE_GATE = gate_q;
  assign VOICE_TRIG = trig_q;
  assign STEAL      = steal_q;

endmodule

// File: doc/voice_alloc.md
Name: voice_alloc

Overview:
- Polyphonic voice allocator between the MIDI parser and a bank of NCOs.
- Successor to the single-voice path, where one NOTE_NUM/NOTE_VEL pair drives one oscillator. This block tracks VOICES independent note slots.
- Each note-on event is assigned to a free voice. When no voice is free, the least-recently-allocated voice is stolen.
- Per-voice note, velocity, gate and trigger outputs feed one NCO per voice.

Parameters:
- VOICES, 4, number of voice slots (2..16).
- RANK_W, 2, width of the per-voice LRU rank; must equal clog2(VOICES).

Ports:
- CLK  input  1  system clock
- RST  input  1  synchronous active-high reset
- CE  input  1  clock enable; when low, no state changes
- EV_VALID  input  1  event strobe; one cycle per MIDI event
- EV_ON  input  1  1 = note-on, 0 = note-off
- EV_NOTE  input  7  MIDI note number
- EV_VEL  input  7  MIDI velocity
- ALL_OFF  input  1  all-notes-off request (e.g. from CC 123)
- VOICE_NOTE  output  VOICES*7  voice i note at [7i+6:7i]
- VOICE_VEL  output  VOICES*7  voice i velocity at [7i+6:7i]
- VOICE_GATE  output  VOICES  voice i is sounding
- VOICE_TRIG  output  VOICES  one-cycle pulse when voice i is (re)allocated
- STEAL  output  1  one-cycle pulse when an allocation stole a gated voice

Behaviour:
- Reset, sampled on a CLK edge with RST=1:
  - VOICE_NOTE=0, VOICE_VEL=0, VOICE_GATE=0, VOICE_TRIG=0, STEAL=0.
  - rank[i]=i; rank 0 is newest, rank VOICES-1 is oldest.
  - RST overrides CE and all events.
- Event accept: on a CLK edge with CE=1 and EV_VALID=1.
  - All outputs are registered; results appear in the cycle after the accepting edge.
  - Single-cycle processing, no backpressure; an event is accepted every cycle it is valid.
- Event classification: EV_ON=1 with EV_VEL=0 is treated as note-off (MIDI running-status convention).
- Note-on target selection, in priority order:
  1. A gated voice with VOICE_NOTE==EV_NOTE: retrigger it. Lowest index wins if duplicates exist.
  2. Otherwise the lowest-index voice with GATE=0.
  3. Otherwise the voice with rank==VOICES-1 (steal), and STEAL pulses.
- Note-on update of the target voice t:
  - NOTE←EV_NOTE, VEL←EV_VEL, GATE←1, TRIG[t] pulses.
  - LRU update: every voice j with rank[j] < rank[t] increments; rank[t]←0.
  - Ranks therefore always remain a permutation of 0..VOICES-1.
- Note-off:
  - Every gated voice with NOTE==EV_NOTE clears GATE.
  - NOTE, VEL and ranks are unchanged, so the NCO can run its release on the held values.
  - No match: ignored, no output change.
- ALL_OFF (CE=1): clears all GATE bits; NOTE, VEL and ranks are held.
  - If EV_VALID is simultaneous, ALL_OFF has priority and the event is dropped.
- VOICE_TRIG and STEAL are high for exactly one cycle after the accepting edge, then return to 0.
  - When CE=0 they are driven to 0 on the next edge.
  - All other state holds while CE=0.
- EV_VALID while CE=0 is ignored, not queued.
- Reset mid-activity: all voices release immediately; pending pulses are cancelled.

Test Plan:
1. VOICES=4, after reset: note-on 60/100, 64/90, 67/80 → voices 0,1,2 hold (60,100),(64,90),(67,80); GATE=0111; TRIG pulses 0001, 0010, 0100 on successive cycles; STEAL never.
2. From scenario 1, add note-on 72/70 then 76/60 → 72 goes to voice 3 (GATE=1111); 76 steals voice 0, the oldest; STEAL=1 for one cycle; voice0=(76,60); TRIG=0001.
3. From scenario 2, note-on 64/127 → voice 1 retriggered with VEL=127, TRIG=0010, STEAL=0; next steal goes to voice 2 (rank order after retrigger: 2 oldest).
4. Note-off 67 → GATE[2]=0, NOTE[2]=67 held. Then note-on 50/100 → voice 2 (free), no steal. Note-on 71/0 → treated as note-off; unmatched, no change.
5. Same cycle: ALL_OFF=1 and EV_VALID=1 with note-on 40/100 → GATE=0000, note 40 absent; next note-on 41/10 → voice 0.
6. CE=0 with EV_VALID pulses → no output changes. Assert RST while GATE=1111 and TRIG pulsing → next cycle all outputs 0; ranks reset so the next four note-ons fill voices 0..3 in order.
